// File: rtl/fifo_rd_ctrl_if.sv
// Read-side handshake bundle between the FIFO read controller and its consumer.
// The rd_level signal exists only when FIFO_RD_LEVEL_EN is defined.
interface fifo_rd_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  rd_inc;
    logic [ADDR_WIDTH:0]   wptr_gray_sync;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic                  empty;
    logic                  rd_underflow;
`ifdef FIFO_RD_LEVEL_EN
    logic [ADDR_WIDTH:0]   rd_level;
`endif

    modport master (
        output rd_inc,
        output wptr_gray_sync,
        input  rd_addr,
        input  rptr_gray,
        input  empty,
`ifdef FIFO_RD_LEVEL_EN
        input  rd_level,
`endif
        input  rd_underflow
    );

    modport slave (
        input  rd_inc,
        input  wptr_gray_sync,
        output rd_addr,
        output rptr_gray,
        output empty,
`ifdef FIFO_RD_LEVEL_EN
        output rd_level,
`endif
        output rd_underflow
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read-side pointer/empty controller (Gray pointer, registered empty).
// Optional registered occupancy output rd_level enabled by macro FIFO_RD_LEVEL_EN.
module fifo_rd_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    fifo_rd_ctrl_if.slave      rd
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray;
    logic [PW-1:0] rgray_next;
    logic          empty_q;
    logic          underflow_q;
    logic          accepted;

    assign accepted   = rd.rd_inc & ~empty_q;
    assign rbin_next  = rbin + PW'(accepted);
    assign rgray_next = rbin_next ^ (rbin_next >> 1);

    // Empty compares the post-read pointer so the last read and empty land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbin        <= '0;
            rgray       <= '0;
            empty_q     <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            rbin        <= rbin_next;
            rgray       <= rgray_next;
            empty_q     <= (rgray_next == rd.wptr_gray_sync);
            underflow_q <= rd.rd_inc & empty_q;
        end
    end

    assign rd.rd_addr      = rbin[ADDR_WIDTH-1:0];
    assign rd.rptr_gray    = rgray;
    assign rd.empty        = empty_q;
    assign rd.rd_underflow = underflow_q;

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_q;

    always_comb begin
        wbin         = '0;
        wbin[PW-1]   = rd.wptr_gray_sync[PW-1];
        for (int unsigned i = 0; i < PW - 1; i++) begin
            wbin[PW-2-i] = wbin[PW-1-i] ^ rd.wptr_gray_sync[PW-2-i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= wbin - rbin_next;
        end
    end

    assign rd.rd_level = level_q;
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl (ADDR_WIDTH=3): count-based model, directed + random stimulus.
module tb_fifo_rd_ctrl;
    localparam int unsigned AW = 3;
    localparam int unsigned PW = AW + 1;

    typedef struct {
        int unsigned   tgt;
        logic [PW-1:0] r;
        logic          e;
        logic          uf;
        logic [PW-1:0] lvl;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    bit done = 1'b0;
    exp_t q[$];

    // model state: read and write counts modulo 2^(AW+1)
    int unsigned mr = 0;
    int unsigned wc = 0;
    bit          mempty = 1'b1;

    fifo_rd_ctrl_if #(.ADDR_WIDTH(AW)) bus ();
    fifo_rd_ctrl #(.ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .rd(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] to_gray(input int unsigned b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the state after the coming edge, then let the edge pass.
    task automatic step(input bit r, input bit inc, input int unsigned w);
        exp_t e;
        rst = r;
        wc = w % 16;
        bus.rd_inc = inc;
        bus.wptr_gray_sync = to_gray(wc);
        e.tgt = cyc + 1;
        if (r) begin
            mr = 0;
            mempty = 1'b1;
            e.uf = 1'b0;
        end else begin
            e.uf = inc && mempty;
            if (inc && !mempty) mr = (mr + 1) % 16;
            mempty = (mr == wc);
        end
        e.r = PW'(mr);
        e.e = mempty;
        e.lvl = r ? '0 : PW'((wc + 16 - mr) % 16);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                e = q.pop_front();
                chk("rd_addr", bus.rd_addr, e.r % 8);
                chk("rptr_gray", bus.rptr_gray, to_gray(e.r));
                chk("empty", bus.empty, e.e);
                chk("rd_underflow", bus.rd_underflow, e.uf);
`ifdef FIFO_RD_LEVEL_EN
                chk("rd_level", bus.rd_level, e.lvl);
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin : stim
        int unsigned w;
        // reset with nonzero write pointer
        step(1, 1, 6);
        // single entry
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 1, 1);
        step(0, 0, 1);
        // full drain of 8 back-to-back reads, then underflow twice
        step(1, 0, 0);
        step(0, 0, 8);
        for (int i = 0; i < 8; i++) step(0, 1, 8);
        step(0, 1, 8);
        step(0, 1, 8);
        step(0, 0, 8);
        // reset mid-drain
        step(1, 0, 0);
        step(0, 0, 8);
        for (int i = 0; i < 5; i++) step(0, 1, 8);
        step(1, 1, 8);
        step(0, 0, 8);
        step(0, 0, 8);
        // level 6 then two reads
        step(1, 0, 0);
        step(0, 0, 6);
        step(0, 1, 6);
        step(0, 1, 6);
        step(0, 0, 6);
        // simultaneous write advance and last read
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 1, 2);
        step(0, 1, 2);
        step(0, 0, 2);
        // random traffic: write pointer advances by at most one, never beyond full
        step(1, 0, 0);
        w = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                w = 0;
                step(1, $urandom_range(0, 1), 0);
            end else begin
                if (((w + 16 - mr) % 16) < 8 && $urandom_range(0, 1) == 1) w = (w + 1) % 16;
                step(0, $urandom_range(0, 1), w);
            end
        end
        step(0, 0, w);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, meaning the FIFO depth is 2^ADDR_WIDTH and pointers are ADDR_WIDTH+1 bits wide, with the MSB as the wrap bit.
REQ-003 clk  input  1  rising-edge clock, read domain.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 rd_inc  input  1  read request from the consumer.
REQ-006 wptr_gray_sync  input  ADDR_WIDTH+1  Gray-coded write pointer, already synchronized into the clk domain.
REQ-007 rd_addr  output  ADDR_WIDTH  binary read address to the FIFO memory.
REQ-008 rptr_gray  output  ADDR_WIDTH+1  registered Gray-coded read pointer, sent to the write-domain synchronizer.
REQ-009 empty  output  1  registered FIFO-empty flag.
REQ-010 rd_underflow  output  1  one-cycle pulse flagging a read request made while empty.

Function
REQ-011 The block SHALL hold an internal binary pointer rbin, ADDR_WIDTH+1 bits wide.
REQ-012 An accepted read SHALL be rd_inc=1 and empty=1'b0 in the same cycle.
REQ-013 rbin_next SHALL be rbin + accepted, modulo 2^(ADDR_WIDTH+1).
REQ-014 rgray_next SHALL be rbin_next XOR (rbin_next >> 1).
REQ-015 On each clk edge the block SHALL register rbin_next into rbin and rgray_next into rptr_gray.
REQ-016 On each clk edge the block SHALL register (rgray_next == wptr_gray_sync) into empty.
REQ-017 rd_addr SHALL equal rbin[ADDR_WIDTH-1:0], taken directly from the register with no added logic.
REQ-018 Read latency SHALL be as follows: rd_addr addresses the current head entry; after an accepted read, rd_addr advances on the next edge.
REQ-019 A read request while empty=1 SHALL be ignored (rbin, rptr_gray and rd_addr unchanged), and rd_underflow SHALL be 1 for exactly the following cycle.
REQ-020 rd_underflow SHALL be 0 in every other cycle.
REQ-021 At wrap-around, rd_addr SHALL return to 0 after address 2^ADDR_WIDTH-1, and the MSB of rbin SHALL toggle.
REQ-022 Empty detection SHALL be a full ADDR_WIDTH+1-bit Gray compare, including the MSB.
REQ-023 rptr_gray SHALL change in at most one bit per clock.
REQ-024 Empty deassertion SHALL occur on the first edge after wptr_gray_sync differs from rptr_gray.
REQ-025 Empty assertion SHALL occur on the same edge that registers the read which makes the pointers equal, so that reads are back-to-back with no bubble.
REQ-026 Simultaneous write-pointer advance and last read SHALL be resolved by the compare against the current wptr_gray_sync, so that empty stays 0 if the pointers remain unequal.

Reset
REQ-027 While rst=1 at an edge, the block SHALL force rbin=0, rptr_gray=0, rd_addr=0, empty=1 and rd_underflow=0, regardless of rd_inc and wptr_gray_sync.
REQ-028 Reset asserted mid-operation SHALL discard pointer state.
REQ-029 After rst is released, empty SHALL be recomputed on the first edge after release.

Configuration
REQ-030 With macro FIFO_RD_LEVEL_EN defined, the block SHALL add output rd_level (ADDR_WIDTH+1 bits, registered), range 0..2^ADDR_WIDTH.
REQ-031 rd_level SHALL equal gray2bin(wptr_gray_sync) - rbin_next, modulo 2^(ADDR_WIDTH+1).
REQ-032 rd_level SHALL reset to 0.
REQ-033 Without FIFO_RD_LEVEL_EN, the rd_level port, the Gray-to-binary decoder and the subtractor SHALL be absent, with all other behaviour identical.

Verification (ADDR_WIDTH=3)
REQ-034 Reset: rst=1 for 1 cycle with wptr_gray_sync=4'b0101 -> rptr_gray=0000, rd_addr=0, empty=1, rd_underflow=0.
REQ-035 Single entry: wptr_gray_sync=0001, rd_inc=0 -> empty=0 after one edge; one rd_inc pulse -> rd_addr=1, rptr_gray=0001, empty=1 on the same edge.
REQ-036 Full drain: wptr_gray_sync=1100 (binary 8), 8 back-to-back reads -> rd_addr goes 0..7 then 0; rptr_gray goes 0001,0011,0010,0110,0111,0101,0100,1100; empty=1 after the 8th read; no extra cycles.
REQ-037 Underflow: empty=1, rd_inc=1 for 2 cycles -> rd_underflow=1 for 2 cycles; rptr_gray unchanged.
REQ-038 Reset mid-drain: after 5 reads (rptr_gray=0111), assert rst -> rptr_gray=0000, rd_addr=0, empty=1; after release with wptr_gray_sync=1100, empty=0 one edge later.
REQ-039 Level (FIFO_RD_LEVEL_EN defined): wptr_gray_sync=0101 (binary 6), 2 reads -> rd_level goes 6, 5, 4; undefined-macro build compiles with no rd_level port.
